// File: rtl/mem_responder_pkg.sv
// Shared CPU memory-access definitions: m_type encodings, responder FSM states,
// default address map and byte-lane helpers used by the M and W stages.
package mem_responder_pkg;

   typedef enum logic [2:0] {
      MT_WORD   = 3'd0,
      MT_HALF_U = 3'd1,
      MT_HALF_S = 3'd2,
      MT_BYTE_U = 3'd3,
      MT_BYTE_S = 3'd4
   } mem_type_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PER_WAIT = 2'd1,
      ST_PER_DONE = 2'd2
   } resp_state_e;

   localparam logic [31:0] DM_TOP_DEFAULT   = 32'h0000_2FFF;
   localparam logic [31:0] PER_BASE_DEFAULT = 32'h0000_7F00;
   localparam logic [31:0] PER_TOP_DEFAULT  = 32'h0000_7F2F;

   // Value of the wait counter during the 255th PER_WAIT cycle.
   localparam logic [7:0]  PER_WAIT_LAST    = 8'd254;

   function automatic logic type_aligned(input logic [2:0] mtype, input logic [1:0] off);
      case (mem_type_e'(mtype))
         MT_WORD:              return off == 2'b00;
         MT_HALF_U, MT_HALF_S: return off[0] == 1'b0;
         MT_BYTE_U, MT_BYTE_S: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] mtype, input logic [1:0] off);
      case (mem_type_e'(mtype))
         MT_WORD:              return 4'b1111;
         MT_HALF_U, MT_HALF_S: return off[1] ? 4'b1100 : 4'b0011;
         MT_BYTE_U, MT_BYTE_S: return 4'b0001 << off;
         default:              return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] lane_replicate(input logic [2:0] mtype, input logic [31:0] data);
      case (mem_type_e'(mtype))
         MT_HALF_U, MT_HALF_S: return {2{data[15:0]}};
         MT_BYTE_U, MT_BYTE_S: return {4{data[7:0]}};
         default:              return data;
      endcase
   endfunction

endpackage

// File: rtl/mem_responder_load_ext.sv
// load_ext: combinational lane select and sign/zero extension of a loaded word,
// shared with the W stage.
module load_ext
   import mem_responder_pkg::*;
(
   input  logic [31:0] in_word,
   input  logic [2:0]  m_type,
   input  logic [1:0]  offset,
   output logic [31:0] data
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      half_sel = offset[1] ? in_word[31:16] : in_word[15:0];
      case (offset)
         2'd0:    byte_sel = in_word[7:0];
         2'd1:    byte_sel = in_word[15:8];
         2'd2:    byte_sel = in_word[23:16];
         default: byte_sel = in_word[31:24];
      endcase

      case (mem_type_e'(m_type))
         MT_WORD:   data = in_word;
         MT_HALF_U: data = {16'h0000, half_sel};
         MT_HALF_S: data = {{16{half_sel[15]}}, half_sel};
         MT_BYTE_U: data = {24'h00_0000, byte_sel};
         MT_BYTE_S: data = {{24{byte_sel[7]}}, byte_sel};
         default:   data = '0;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// M-stage memory responder: single-cycle data-memory port plus a stalling peripheral
// handshake. Define MEM_RESPONDER_TIMEOUT_EN to abandon peripheral waits after 255 cycles.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter logic [31:0] DM_TOP   = DM_TOP_DEFAULT,
   parameter logic [31:0] PER_BASE = PER_BASE_DEFAULT,
   parameter logic [31:0] PER_TOP  = PER_TOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        m_valid,
   input  logic        m_we,
   input  logic [2:0]  m_type,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        adel,
   output logic        ades,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic        per_req,
   output logic        per_we,
   output logic [31:0] per_addr,
   output logic [3:0]  per_be,
   output logic [31:0] per_wdata,
   input  logic        per_ack,
   input  logic [31:0] per_rdata
`ifdef MEM_RESPONDER_TIMEOUT_EN
   ,
   output logic        per_timeout
`endif
);

   resp_state_e state_q, state_d;
   logic [31:0] per_addr_q, per_addr_d;
   logic        per_we_q, per_we_d;
   logic [31:0] per_wdata_q, per_wdata_d;
   logic [31:0] cap_q, cap_d;
   logic        w_load_q, w_load_d;
   logic [2:0]  w_type_q, w_type_d;
   logic [1:0]  w_off_q, w_off_d;
   logic        w_per_q, w_per_d;

   logic        in_dm, in_per, legal, go;
   logic        per_start, timeout_hit;
   logic [3:0]  be;
   logic [31:0] wdata_rep, ext_src, ext_data;

   always_comb begin
      in_dm     = m_addr <= DM_TOP;
      in_per    = (m_addr >= PER_BASE) && (m_addr <= PER_TOP) && !in_dm;
      legal     = type_aligned(m_type, m_addr[1:0]) &&
                  (in_dm || (in_per && (m_type == MT_WORD)));
      go        = m_valid && !req && legal;
      be        = lane_be(m_type, m_addr[1:0]);
      wdata_rep = lane_replicate(m_type, m_wdata);
   end

   assign adel     = m_valid && !m_we && !legal;
   assign ades     = m_valid && m_we && !legal;
   assign dm_addr  = {m_addr[31:2], 2'b00};
   assign dm_wdata = wdata_rep;
   assign dm_be    = (go && m_we && in_dm && (state_q != ST_PER_WAIT)) ? be : 4'b0000;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d   = state_q;
      stall     = 1'b0;
      per_req   = 1'b0;
      per_start = 1'b0;
      cap_d     = cap_q;
      case (state_q)
         ST_PER_WAIT: begin
            per_req = 1'b1;
            if (per_ack) begin
               cap_d   = per_rdata;
               state_d = ST_PER_DONE;
            end else if (timeout_hit) begin
               cap_d   = '0;
               state_d = ST_PER_DONE;
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            // PER_DONE behaves like IDLE so back-to-back accesses are accepted.
            state_d = ST_IDLE;
            if (go && in_per) begin
               per_req   = 1'b1;
               stall     = 1'b1;
               per_start = 1'b1;
               state_d   = ST_PER_WAIT;
            end
         end
      endcase
   end

   always_comb begin
      per_addr_d  = per_addr_q;
      per_we_d    = per_we_q;
      per_wdata_d = per_wdata_q;
      if (per_start) begin
         per_addr_d  = m_addr;
         per_we_d    = m_we;
         per_wdata_d = wdata_rep;
      end
   end

   assign per_addr  = (state_q == ST_PER_WAIT) ? per_addr_q  : m_addr;
   assign per_we    = (state_q == ST_PER_WAIT) ? per_we_q    : m_we;
   assign per_wdata = (state_q == ST_PER_WAIT) ? per_wdata_q : wdata_rep;
   assign per_be    = per_req ? 4'b1111 : 4'b0000;

   // W-side load info; a stalled or flushed M cycle hands W a bubble.
   always_comb begin
      if (state_q == ST_PER_WAIT) begin
         w_load_d = !stall && !per_we_q;
         w_type_d = MT_WORD;
         w_off_d  = 2'b00;
         w_per_d  = 1'b1;
      end else begin
         w_load_d = go && !m_we && !stall;
         w_type_d = m_type;
         w_off_d  = m_addr[1:0];
         w_per_d  = in_per;
      end
      if (!w_load_d) begin
         w_type_d = MT_WORD;
         w_off_d  = 2'b00;
         w_per_d  = 1'b0;
      end
   end

`ifdef MEM_RESPONDER_TIMEOUT_EN
   logic [7:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d  = (state_q == ST_PER_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
      timeout_hit = (state_q == ST_PER_WAIT) && !per_ack && (wait_cnt_q == PER_WAIT_LAST);
   end

   assign per_timeout = timeout_hit;

   always_ff @(posedge clk) begin
      if (rst) wait_cnt_q <= '0;
      else     wait_cnt_q <= wait_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign ext_src = w_per_q ? cap_q : dm_rdata;

   load_ext u_load_ext (
      .in_word (ext_src),
      .m_type  (w_type_q),
      .offset  (w_off_q),
      .data    (ext_data)
   );

   assign rdata = w_load_q ? ext_data : '0;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (rst) begin
         state_q     <= ST_IDLE;
         per_addr_q  <= '0;
         per_we_q    <= 1'b0;
         per_wdata_q <= '0;
         cap_q       <= '0;
         w_load_q    <= 1'b0;
         w_type_q    <= MT_WORD;
         w_off_q     <= 2'b00;
         w_per_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         per_addr_q  <= per_addr_d;
         per_we_q    <= per_we_d;
         per_wdata_q <= per_wdata_d;
         cap_q       <= cap_d;
         w_load_q    <= w_load_d;
         w_type_q    <= w_type_d;
         w_off_q     <= w_off_d;
         w_per_q     <= w_per_d;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed corner cases plus random accesses
// compared against an address-map / byte-arithmetic reference model.
module tb_mem_responder;

   localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;
   localparam logic [31:0] PER_BASE = 32'h0000_7F00;
   localparam logic [31:0] PER_TOP  = 32'h0000_7F2F;

   logic        clk, rst, req, m_valid, m_we;
   logic [2:0]  m_type;
   logic [31:0] m_addr, m_wdata;
   logic        stall, adel, ades;
   logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be, per_be;
   logic        per_req, per_we, per_ack;
   logic [31:0] per_addr, per_wdata, per_rdata;
`ifdef MEM_RESPONDER_TIMEOUT_EN
   logic        per_timeout;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .m_valid   (m_valid),
      .m_we      (m_we),
      .m_type    (m_type),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .stall     (stall),
      .rdata     (rdata),
      .adel      (adel),
      .ades      (ades),
      .dm_addr   (dm_addr),
      .dm_be     (dm_be),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .per_req   (per_req),
      .per_we    (per_we),
      .per_addr  (per_addr),
      .per_be    (per_be),
      .per_wdata (per_wdata),
      .per_ack   (per_ack),
      .per_rdata (per_rdata)
`ifdef MEM_RESPONDER_TIMEOUT_EN
      ,
      .per_timeout (per_timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [31:0] idx);
      return (idx * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
   endfunction

   // Synchronous data RAM with one-cycle read latency.
   logic [31:0] ram [logic [31:0]];
   logic [31:0] ram_idx, ram_old, ram_new;

   always @(posedge clk) begin
      ram_idx = dm_addr >> 2;
      ram_old = ram.exists(ram_idx) ? ram[ram_idx] : init_word(ram_idx);
      ram_new = ram_old;
      for (int i = 0; i < 4; i++)
         if (dm_be[i]) ram_new[8*i +: 8] = dm_wdata[8*i +: 8];
      if (dm_be != 4'b0000) ram[ram_idx] = ram_new;
      dm_rdata <= ram_old;
   end

   // Reference model of data memory contents.
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] w;
      w = ref_read(a);
      for (int i = 0; i < 4; i++)
         if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[a >> 2] = w;
   endtask

   function automatic int unsigned access_size(input logic [2:0] t);
      return (t == 3'd0) ? 4 : (t <= 3'd2) ? 2 : 1;
   endfunction

   function automatic logic model_legal(input logic [2:0] t, input logic [31:0] a);
      int unsigned sz;
      if (t > 3'd4) return 1'b0;
      sz = access_size(t);
      if ((a % sz) != 0) return 1'b0;
      if (a <= DM_TOP) return 1'b1;
      return (a >= PER_BASE) && (a <= PER_TOP) && (sz == 4);
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
      int unsigned sz;
      sz = access_size(t);
      return 4'(((1 << sz) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] model_rep(input logic [2:0] t, input logic [31:0] d);
      case (access_size(t))
         4:       return d;
         2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
         default: return (d & 32'h0000_00FF) * 32'h0101_0101;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] t,
                                              input logic [31:0] a);
      logic [31:0] x;
      x = w >> (8 * (a % 4));
      case (t)
         3'd0:    return w;
         3'd1:    return x & 32'h0000_FFFF;
         3'd2:    return (x & 32'h0000_FFFF) | (x[15] ? 32'hFFFF_0000 : 32'h0);
         3'd3:    return x & 32'h0000_00FF;
         3'd4:    return (x & 32'h0000_00FF) | (x[7] ? 32'hFFFF_FF00 : 32'h0);
         default: return 32'h0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // One M-stage access followed by its W cycle; entered and left just after a posedge.
   task automatic access(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_dly, input logic flush,
                         input logic req_in_wait);
      logic        legal, in_dm, in_per, go_dm, go_per;
      logic [3:0]  be;
      logic [31:0] rep, exp_rd, pr;
      legal  = model_legal(t, a);
      in_dm  = a <= DM_TOP;
      in_per = (a >= PER_BASE) && (a <= PER_TOP);
      go_dm  = legal && !flush && in_dm;
      go_per = legal && !flush && in_per;
      be     = model_be(t, a);
      rep    = model_rep(t, wd);
      exp_rd = 32'h0;
      pr     = 32'h0;

      m_valid = 1'b1; m_we = we; m_type = t; m_addr = a; m_wdata = wd; req = flush;
      @(negedge clk);
      check("adel", adel, !we && !legal);
      check("ades", ades, we && !legal);
      check("dm_be", dm_be, (go_dm && we) ? be : 4'b0000);
      if (go_dm && we) begin
         check("dm_wdata", dm_wdata, rep);
         ref_write(a, be, rep);
      end
      if (go_dm && !we) exp_rd = model_load(ref_read(a), t, a);
      check("per_req", per_req, go_per);
      check("stall", stall, go_per);

      if (go_per) begin
         check("per_addr", per_addr, a);
         check("per_we", per_we, we);
         check("per_be", per_be, 4'b1111);
         check("per_wdata", per_wdata, wd);
         for (int k = 1; k <= ack_dly; k++) begin
            @(posedge clk); #1;
            req = req_in_wait;
            if (k == ack_dly) begin
               pr        = $urandom;
               per_ack   = 1'b1;
               per_rdata = pr;
            end
            @(negedge clk);
            check("wait_per_req", per_req, 1'b1);
            check("wait_stall", stall, k != ack_dly);
            check("wait_per_addr", per_addr, a);
            check("wait_per_we", per_we, we);
            check("wait_per_wdata", per_wdata, wd);
         end
         if (!we) exp_rd = pr;
      end

      @(posedge clk); #1;
      m_valid = 1'b0; req = 1'b0; per_ack = 1'b0; per_rdata = $urandom;
      @(negedge clk);
      check("w_rdata", rdata, exp_rd);
      check("w_stall", stall, 1'b0);
      check("w_per_req", per_req, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic reset_mid_wait();
      m_valid = 1'b1; m_we = 1'b0; m_type = 3'd0; m_addr = 32'h0000_7F08; req = 1'b0;
      @(negedge clk);
      check("rst_req_start", per_req, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_wait_stall", stall, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; m_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_per_req", per_req, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_dm_be", dm_be, 4'b0000);
      check("rst_rdata", rdata, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      per_ack = 1'b1; per_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("late_ack_req", per_req, 1'b0);
      check("late_ack_stall", stall, 1'b0);
      @(posedge clk); #1;
      per_ack = 1'b0;
      @(negedge clk);
      check("late_ack_rdata", rdata, 32'h0);
      @(posedge clk); #1;
   endtask

`ifdef MEM_RESPONDER_TIMEOUT_EN
   task automatic timeout_test();
      m_valid = 1'b1; m_we = 1'b0; m_type = 3'd0; m_addr = PER_BASE; req = 1'b0;
      per_ack = 1'b0; per_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("to_req", per_req, 1'b1);
      for (int k = 1; k <= 255; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("to_pulse", per_timeout, k == 255);
         check("to_stall", stall, k != 255);
      end
      @(posedge clk); #1;
      m_valid = 1'b0;
      @(negedge clk);
      check("to_after_req", per_req, 1'b0);
      check("to_after_pulse", per_timeout, 1'b0);
      check("to_rdata", rdata, 32'h0);
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      logic        we, fl;
      logic [2:0]  t;
      logic [31:0] a;
      int unsigned sel;

      rst = 1'b1; req = 1'b0; m_valid = 1'b0; m_we = 1'b0; m_type = 3'd0;
      m_addr = 32'h0; m_wdata = 32'h0; per_ack = 1'b0; per_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_stall", stall, 1'b0);
      check("reset_per_req", per_req, 1'b0);
      check("reset_dm_be", dm_be, 4'b0000);
      check("reset_rdata", rdata, 32'h0);
      @(posedge clk); #1;

      access(1'b1, 3'd0, 32'h0000_0000, 32'h80FF_1234, 1, 1'b0, 1'b0);  // sw
      access(1'b0, 3'd4, 32'h0000_0003, 32'h0, 1, 1'b0, 1'b0);          // lb -> FFFF_FF80
      access(1'b1, 3'd1, 32'h0000_0002, 32'h0000_ABCD, 1, 1'b0, 1'b0);  // sh
      access(1'b0, 3'd1, 32'h0000_0001, 32'h0, 1, 1'b0, 1'b0);          // misaligned lh
      access(1'b0, 3'd0, 32'h0000_7F04, 32'h0, 3, 1'b0, 1'b0);          // lw, 3 stall cycles
      access(1'b1, 3'd0, 32'h0000_7F10, 32'h1111_2222, 2, 1'b1, 1'b0);  // flushed sw
      access(1'b1, 3'd0, 32'h0000_7F10, 32'h3333_4444, 4, 1'b0, 1'b1);  // req during wait
      access(1'b0, 3'd0, DM_TOP - 3, 32'h0, 1, 1'b0, 1'b0);
      access(1'b0, 3'd0, DM_TOP + 1, 32'h0, 1, 1'b0, 1'b0);
      access(1'b1, 3'd3, DM_TOP, 32'h0000_005A, 1, 1'b0, 1'b0);
      access(1'b0, 3'd0, PER_TOP - 3, 32'h0, 2, 1'b0, 1'b0);
      access(1'b0, 3'd0, PER_TOP + 1, 32'h0, 1, 1'b0, 1'b0);
      access(1'b0, 3'd1, PER_BASE, 32'h0, 1, 1'b0, 1'b0);
      access(1'b1, 3'd0, PER_BASE - 4, 32'h0, 1, 1'b0, 1'b0);
      reset_mid_wait();

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 4)      a = $urandom_range(0, DM_TOP);
         else if (sel <= 6) a = DM_TOP - 7 + $urandom_range(0, 15);
         else if (sel <= 8) a = PER_BASE - 8 + $urandom_range(0, PER_TOP - PER_BASE + 16);
         else               a = $urandom;
         we = $urandom_range(0, 1);
         if (we) begin
            sel = $urandom_range(0, 2);
            t   = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : 3'd3;
         end else begin
            t = 3'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 9) < 7) a = a - (a % access_size(t));
         fl = model_legal(t, a) && ($urandom_range(0, 9) == 0);
         access(we, t, a, $urandom, $urandom_range(1, 5), fl, 1'b0);
      end

`ifdef MEM_RESPONDER_TIMEOUT_EN
      timeout_test();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DM_TOP, default 32'h0000_2FFF: last byte address of data memory; DM base is 0.
REQ-002 SHALL have parameter PER_BASE, default 32'h0000_7F00: first peripheral byte address.
REQ-003 SHALL have parameter PER_TOP, default 32'h0000_7F2F: last peripheral byte address.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  interrupt/exception flush of the M-stage instruction.
REQ-007 m_valid  in  1  M stage holds a memory instruction.
REQ-008 m_we  in  1  1 = store, 0 = load.
REQ-009 m_type  in  3  0 word, 1 half-unsigned, 2 half-signed, 3 byte-unsigned, 4 byte-signed; stores use 0/1/3.
REQ-010 m_addr  in  32  byte address.
REQ-011 m_wdata  in  32  store data, right-aligned.
REQ-012 stall  out  1  freeze the F/D/E/M pipeline.
REQ-013 rdata  out  32  aligned, extended load data for the W stage.
REQ-014 adel / ades  out  1 each  load/store address error, combinational in the M cycle.
REQ-015 dm_addr  out  32, dm_be  out  4, dm_wdata  out  32: synchronous RAM port; dm_rdata  in  32, one-cycle read latency.
REQ-016 per_req  out  1, per_we  out  1, per_addr  out  32, per_be  out  4, per_wdata  out  32, per_ack  in  1, per_rdata  in  32.

Function
REQ-017 Access SHALL be legal only when aligned (word: addr[1:0]=0; half: addr[0]=0) and inside [0,DM_TOP] or [PER_BASE,PER_TOP]; peripheral accesses SHALL be word-only; anything else raises adel (load) or ades (store) and issues no access.
REQ-018 Byte enables SHALL be derived from m_type and addr[1:0]; store data SHALL be replicated to the enabled lanes.
REQ-019 DM accesses SHALL never stall: dm_be is non-zero only for a legal store with m_valid=1 and req=0.
REQ-020 The FSM SHALL have states IDLE, PER_WAIT, PER_DONE.
REQ-021 In IDLE, a legal peripheral access with m_valid=1 and req=0 SHALL assert per_req and stall combinationally, then move to PER_WAIT.
REQ-022 In PER_WAIT, per_req and stall SHALL stay high with per_addr/per_we/per_wdata held constant until per_ack=1.
REQ-023 In the per_ack cycle, stall SHALL drop, per_rdata SHALL be captured, and the FSM SHALL move to PER_DONE.
REQ-024 PER_DONE SHALL last one cycle (the W cycle of that instruction) and then return to IDLE; a new access in the same cycle is accepted as if from IDLE.
REQ-025 The load type and addr[1:0] SHALL be registered at the edge that advances M to W; rdata is derived in W from dm_rdata, or from the captured per_rdata when the source flag indicates a peripheral access.
REQ-026 For non-loads, rdata SHALL be 0.
REQ-027 req=1 in IDLE SHALL suppress the access.
REQ-028 req=1 in PER_WAIT SHALL not abort the handshake.
REQ-029 On a req flush, the W-side registers SHALL be cleared so that rdata=0 in the following cycle.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL go to IDLE, the registered type, offset and source SHALL clear, and the capture buffer SHALL be 0.
REQ-031 After reset, stall=0, per_req=0, dm_be=0 and rdata=0 in the next cycle.
REQ-032 Reset mid-PER_WAIT SHALL drop per_req in the next cycle; a late per_ack SHALL be ignored in IDLE.

Configuration
REQ-033 With MEM_RESPONDER_TIMEOUT_EN defined, an 8-bit counter SHALL run in PER_WAIT.
REQ-034 If 255 cycles pass without per_ack, the handshake SHALL be abandoned: per_req drops, a 1-cycle per_timeout output pulses, the captured data is 0, and the FSM goes to PER_DONE.
REQ-035 Without MEM_RESPONDER_TIMEOUT_EN, neither the counter nor the per_timeout port SHALL exist, and PER_WAIT waits indefinitely.

Structure
REQ-036 The m_type encodings, the FSM state enum and the default address constants SHALL live in the shared CPU package.
REQ-037 One sub-module, load_ext, SHALL perform combinational lane select and sign/zero extension, reusable by the W stage.

Verification
REQ-038 lb at 0x0000_0003 with dm word 0x80FF_1234 -> rdata=0xFFFF_FF80 in W; stall stays 0.
REQ-039 sh of 0x0000_ABCD at 0x0000_0002 -> dm_be=4'b1100, dm_wdata=0xABCD_ABCD; lh at 0x0000_0001 -> adel=1, dm_be=0.
REQ-040 lw at 0x7F04 with per_ack after 3 cycles and per_rdata=0x1234_5678 -> stall high for 3 cycles, then rdata=0x1234_5678.
REQ-041 sw to 0x7F10 with req=1 in the same cycle -> per_req stays 0; req during PER_WAIT -> handshake completes.
REQ-042 rst during PER_WAIT -> next cycle per_req=0 and stall=0; an ack 2 cycles later has no effect.
REQ-043 With MEM_RESPONDER_TIMEOUT_EN and no ack -> per_timeout pulses on the 255th wait cycle, then rdata=0.
